// File: rtl/seq_div_nc_pkg.sv
// -----------------------------------------------------------------------------
// seq_div_pkg
// Shared types and width constants for the sequential restoring divider
// seq_div_nc. The divider recovers one multiplier operand from a 2W-bit
// product and the other W-bit operand.
//   W            : divisor / remainder width
//   DW           : dividend / quotient width (2W)
//   PW           : partial-remainder width (W+1, one guard bit for the trial
//                  subtract sign)
//   CW           : iteration counter width, wide enough to count 0..2W
//   DBZ_QUOTIENT : quotient reported when the divisor is zero
// -----------------------------------------------------------------------------
package seq_div_pkg;

    localparam int W  = 4;
    localparam int DW = 2 * W;
    localparam int PW = W + 1;
    localparam int CW = $clog2(2 * W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [DW-1:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/seq_div_nc_if.sv
// -----------------------------------------------------------------------------
// seq_div_nc_if
// Operand / result handshake bundle for seq_div_nc.
//   in_valid, in_ready   : operand handshake (producer -> divider)
//   dividend [DW]        : product to divide
//   divisor  [W]         : known operand
//   out_valid, out_ready : result handshake (divider -> consumer)
//   quotient [DW]        : recovered operand
//   remainder [W]        : dividend mod divisor
//   div_by_zero          : divisor was zero for this result
// master = the side driving operands and consuming results (the testbench /
// surrounding flow); slave = the divider.
// -----------------------------------------------------------------------------
interface seq_div_nc_if import seq_div_pkg::*; ();

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [W-1:0]  divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [W-1:0]  remainder;
    logic          div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/seq_div_nc_div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration: shift the next dividend bit
// into the partial remainder, trial-subtract the divisor, keep the difference
// if it did not go negative.
//   p_i     [PW] : current partial remainder
//   q_msb_i      : dividend bit being brought down (MSB of the Q shift reg)
//   d_i     [W]  : divisor
//   p_o     [PW] : next partial remainder
//   q_bit_o      : quotient bit produced by this iteration
// -----------------------------------------------------------------------------
module div_step
    import seq_div_pkg::*;
(
    input  logic [PW-1:0] p_i,
    input  logic          q_msb_i,
    input  logic [W-1:0]  d_i,
    output logic [PW-1:0] p_o,
    output logic          q_bit_o
);

    logic [PW-1:0] shifted;
    logic [PW-1:0] trial;
    logic          unused_p_msb;

    // After any kept subtract P < D, so P's guard bit is always zero here;
    // only the low W bits take part in the shift.
    assign unused_p_msb = p_i[W];

    assign shifted = {p_i[W-1:0], q_msb_i};
    assign trial   = shifted - {1'b0, d_i};

    // shifted < 2D, so a negative trial wraps to >= 2^W and sets the guard bit;
    // a non-negative trial is < D and leaves it clear.
    assign q_bit_o = ~trial[W];
    assign p_o     = q_bit_o ? trial : shifted;

endmodule

// File: rtl/seq_div_nc.sv
// -----------------------------------------------------------------------------
// seq_div_nc
// Sequential unsigned restoring divider, one quotient bit per cycle, MSB first.
// Back-computes a multiplier operand from a product: quotient = dividend /
// divisor, remainder = dividend % divisor. A zero divisor finishes at once
// with quotient all ones, remainder = dividend low bits and div_by_zero set.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset, aborts any division in progress
//   bus   : seq_div_nc_if.slave operand / result handshake
// Latency: result valid 2W+1 edges after the accept edge (counting that edge),
// one edge for divide-by-zero. Results hold under unbounded backpressure and
// remain on the outputs until the next accepted operand set.
// -----------------------------------------------------------------------------
module seq_div_nc
    import seq_div_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    seq_div_nc_if.slave   bus
);

    state_e        state_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic [DW-1:0] quotient_q;
    logic [W-1:0]  remainder_q;
    logic          dbz_q;

    logic [PW-1:0] p_q;
    logic [DW-1:0] q_q;
    logic [W-1:0]  d_q;
    logic [CW-1:0] cnt_q;

    logic [PW-1:0] p_d;
    logic          q_bit_d;
    logic [DW-1:0] q_d;

    div_step u_step (
        .p_i     (p_q),
        .q_msb_i (q_q[DW-1]),
        .d_i     (d_q),
        .p_o     (p_d),
        .q_bit_o (q_bit_d)
    );

    // Q doubles as dividend shifter and quotient accumulator.
    assign q_d = {q_q[DW-2:0], q_bit_d};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            p_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        q_q        <= bus.dividend;
                        d_q        <= bus.divisor;
                        p_q        <= '0;
                        cnt_q      <= '0;
                        dbz_q      <= 1'b0;
                        in_ready_q <= 1'b0;
                        if (bus.divisor != '0) begin
                            state_q <= BUSY;
                        end else begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            quotient_q  <= DBZ_QUOTIENT;
                            remainder_q <= bus.dividend[W-1:0];
                            dbz_q       <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    p_q   <= p_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + CW'(1);
                    // Final iteration: publish this cycle's step result directly.
                    if (cnt_q == CW'(DW - 1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        quotient_q  <= q_d;
                        remainder_q <= p_d[W-1:0];
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div_nc.sv
module tb_seq_div_nc;
    import seq_div_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_div_nc_if bus ();

    seq_div_nc dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division; zero divisor per the defined fallback.
    function automatic void model(input logic [7:0] dd, input logic [3:0] dv,
                                  output logic [7:0] q, output logic [3:0] r,
                                  output logic z, output int lat);
        if (dv == 4'd0) begin
            q = 8'hFF; r = dd[3:0]; z = 1'b1; lat = 1;
        end else begin
            q = 8'(int'(dd) / int'(dv));
            r = 4'(int'(dd) % int'(dv));
            z = 1'b0;
            lat = 2 * W + 1;
        end
    endfunction

    // Present operands at a negedge, count edges (accept edge = 1) until
    // out_valid, hold backpressure for 'hold' cycles, then complete handshake.
    task automatic run_op(input logic [7:0] dd, input logic [3:0] dv, input int hold,
                          output logic [7:0] q, output logic [3:0] r,
                          output logic z, output int lat);
        int guard;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk); guard++;
        end
        if (bus.in_ready !== 1'b1) chk("in_ready_wait", bus.in_ready, 1);
        bus.in_valid = 1'b1; bus.dividend = dd; bus.divisor = dv;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk); lat++;
        end
        q = bus.quotient; r = bus.remainder; z = bus.div_by_zero;
        repeat (hold) @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0] dd;
        logic [3:0] dv;
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
        int         lat;
    } vec_t;

    vec_t vt[8];

    initial begin
        logic [7:0] q, eq, sq;
        logic [3:0] r, er, sr, dv;
        logic [7:0] dd;
        logic       z, ez, sz, stable, inr_ok, none;
        int         lat, elat;

        vt[0] = '{8'hE1, 4'hF, 8'h0F, 4'h0, 1'b0, 9};
        vt[1] = '{8'h64, 4'h7, 8'h0E, 4'h2, 1'b0, 9};
        vt[2] = '{8'hFF, 4'h1, 8'hFF, 4'h0, 1'b0, 9};
        vt[3] = '{8'h05, 4'h0, 8'hFF, 4'h5, 1'b1, 1};
        vt[4] = '{8'hC8, 4'h9, 8'h16, 4'h2, 1'b0, 9};
        vt[5] = '{8'h00, 4'h5, 8'h00, 4'h0, 1'b0, 9};
        vt[6] = '{8'hFE, 4'hF, 8'h10, 4'hE, 1'b0, 9};
        vt[7] = '{8'hA7, 4'h0, 8'hFF, 4'h7, 1'b1, 1};

        bus.in_valid = 1'b0; bus.dividend = '0; bus.divisor = '0; bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_quotient", bus.quotient, 0);
        chk("rst_remainder", bus.remainder, 0);
        chk("rst_dbz", bus.div_by_zero, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table
        foreach (vt[i]) begin
            run_op(vt[i].dd, vt[i].dv, i % 3, q, r, z, lat);
            chk("tbl_quotient", q, vt[i].q);
            chk("tbl_remainder", r, vt[i].r);
            chk("tbl_dbz", z, vt[i].z);
            chk("tbl_latency", lat, vt[i].lat);
            chk("tbl_idle_after", bus.in_ready, 1);
        end

        // Backpressure: result held 20 cycles, in_valid pulses ignored
        bus.in_valid = 1'b1; bus.dividend = 8'h64; bus.divisor = 4'h7;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk); lat++;
        end
        chk("bp_latency", lat, 9);
        sq = bus.quotient; sr = bus.remainder; sz = bus.div_by_zero;
        stable = 1'b1; inr_ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
            bus.in_valid = c[0]; bus.dividend = 8'($urandom); bus.divisor = 4'h3;
            @(negedge clk);
            if (bus.quotient !== sq || bus.remainder !== sr || bus.div_by_zero !== sz ||
                bus.out_valid !== 1'b1) stable = 1'b0;
            if (bus.in_ready !== 1'b0) inr_ok = 1'b0;
        end
        chk("bp_stable", stable, 1);
        chk("bp_in_ready_low", inr_ok, 1);
        chk("bp_quotient", bus.quotient, 8'h0E);
        chk("bp_remainder", bus.remainder, 4'h2);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp_release_in_ready", bus.in_ready, 1);
        chk("bp_release_out_valid", bus.out_valid, 0);
        chk("bp_retained_quotient", bus.quotient, 8'h0E);
        @(negedge clk);
        chk("bp_no_stray_accept", bus.in_ready, 1);

        // Reset during BUSY aborts, then a fresh run completes
        bus.in_valid = 1'b1; bus.dividend = 8'hC8; bus.divisor = 4'h9;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_in_ready", bus.in_ready, 1);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_quotient", bus.quotient, 0);
        chk("midrst_remainder", bus.remainder, 0);
        chk("midrst_dbz", bus.div_by_zero, 0);
        none = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) none = 1'b0;
        end
        chk("midrst_no_result", none, 1);
        run_op(8'hC8, 4'h9, 0, q, r, z, lat);
        chk("midrst_fresh_quotient", q, 8'h16);
        chk("midrst_fresh_remainder", r, 4'h2);
        chk("midrst_fresh_latency", lat, 9);

        // Random operands including zero divisors
        for (int i = 0; i < 150; i++) begin
            dd = 8'($urandom);
            dv = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
            model(dd, dv, eq, er, ez, elat);
            run_op(dd, dv, $urandom_range(0, 2), q, r, z, lat);
            chk("rnd_quotient", q, eq);
            chk("rnd_remainder", r, er);
            chk("rnd_dbz", z, ez);
            chk("rnd_latency", lat, elat);
        end

        // Exhaustive nonzero-divisor sweep
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                run_op(8'(a), 4'(b), $urandom_range(0, 2), q, r, z, lat);
                chk("sweep_invariant",
                    (int'(q) * b + int'(r) == a) && (int'(r) < b) && (z == 1'b0), 1);
                chk("sweep_latency", lat, 9);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_div_nc.md
Name: seq_div_nc

Overview:
- Sequential restoring divider that inverts the 4x4 multiplier datapath: takes a 2W-bit product and a W-bit operand and recovers the other operand (quotient) plus remainder.
- Used in the accuracy-evaluation flow to back-compute operands from approximate products.
- Sits between the multiplier output register and the error-analysis logic; valid/ready handshake on both sides.

Parameters:
- W, 4, divisor and remainder width; dividend and quotient are 2W bits.

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  dividend/divisor valid
- in_ready  output  1  block can accept operands
- dividend  input  2W  product to divide (R)
- divisor  input  W  known operand (B)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quotient  output  2W  recovered operand
- remainder  output  W  dividend mod divisor
- div_by_zero  output  1  divisor was 0 for this result

Behaviour:
- Reset (rst_n low at a rising edge): state=IDLE; in_ready=1; out_valid=0; quotient=0; remainder=0; div_by_zero=0; iteration counter=0. Applies in any state and aborts a division in progress; no result is produced for the aborted operands.
- States: IDLE, BUSY, DONE.
  - in_ready=1 only in IDLE.
  - out_valid=1 only in DONE.
- IDLE:
  - On in_valid&&in_ready: capture dividend into shift register Q, divisor into D, clear partial remainder P (W+1 bits), clear counter, clear div_by_zero.
  - If divisor!=0, go to BUSY.
  - If divisor==0, go to DONE directly with quotient={2W{1}}, remainder=dividend[W-1:0], div_by_zero=1.
- BUSY, one iteration per cycle, MSB first:
  - T = {P[W-1:0], Q[2W-1]} minus {1'b0, D}, computed at W+1 bits.
  - If T is non-negative: P=T and shift 1 into Q LSB.
  - Otherwise: P={P[W-1:0], Q[2W-1]} and shift 0 into Q LSB.
  - Counter increments each cycle.
  - After the 2W-th iteration, go to DONE; quotient=Q and remainder=P[W-1:0] are registered.
- Latency: the handshake edge at cycle k makes out_valid first high in the cycle following edge k+2W, i.e. 2W+1 edges after capture, 9 edges for W=4. Divide-by-zero latency is 1 edge.
- DONE:
  - Outputs held stable while out_ready=0; unbounded backpressure is allowed.
  - On out_valid&&out_ready, go to IDLE; out_valid drops on the next cycle.
  - Output values are retained until the next capture.
  - No back-to-back accept in the same cycle: a new accept is possible at the earliest one cycle after the output handshake.
- in_valid while not in IDLE is ignored; operands are not sampled.
- Arithmetic is unsigned. Quotient occupies the full 2W bits, so no overflow case exists. Remainder < divisor always holds when div_by_zero=0.
- Invariant checked by the verification engineer: quotient*divisor+remainder == dividend whenever div_by_zero=0.

Decomposition:
- Shared package seq_div_pkg holds:
  - the state enum (IDLE, BUSY, DONE)
  - the width-derived localparams: DW=2W, PW=W+1, CW=$clog2(2W+1)
  - DBZ_QUOTIENT constant (all ones)
- One sub-module, div_step: combinational trial-subtract-and-shift.
  - Inputs: P, Q MSB, D.
  - Outputs: next P, quotient bit.
  - Instantiated once in BUSY datapath.

Test Plan:
- Reset then in_valid with dividend=0xE1, divisor=0xF -> quotient=0x0F, remainder=0x0, div_by_zero=0; out_valid exactly 9 edges after accept.
- dividend=0x64, divisor=0x7 -> quotient=0x0E, remainder=0x2; dividend=0xFF, divisor=0x1 -> quotient=0xFF, remainder=0x0.
- dividend=0x05, divisor=0x0 -> out_valid after 1 edge with quotient=0xFF, remainder=0x5, div_by_zero=1.
- Backpressure: hold out_ready=0 for 20 cycles after done -> outputs stable, in_ready=0, in_valid pulses ignored; raise out_ready -> IDLE next cycle, in_ready=1.
- Reset mid-BUSY: drive rst_n=0 at iteration 3 of 0xC8/0x9 -> next cycle IDLE, out_valid=0, outputs 0; a fresh 0xC8/0x9 then yields quotient=0x16, remainder=0x2.
- Exhaustive sweep of all 256x15 dividend/nonzero-divisor pairs with random out_ready -> every result satisfies quotient*divisor+remainder==dividend and remainder<divisor.
